guncelleme_zamanlayici: RTL and testbench

GUNCELLEME_ZAMANLAYICI -- requirements
Module: guncelleme_zamanlayici

---
 rtl/guncelleme_zamanlayici.sv | 161 ++++++++++++++++
 tb/tb_guncelleme_zamanlayici.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/guncelleme_zamanlayici.sv
// Predictor update scheduler: round-robin arbitration of branch/jump updates into a FIFO drained into a registered update port.
// Optional macro GUNCELLEME_BYPASS_EN loads an accepted request straight into the output register when the queue is empty.
module guncelleme_zamanlayici #(
   parameter int DERINLIK = 4
) (
   input  logic        clk_g,
   input  logic        rst_g,
   input  logic        i_br_gecerli,
   output logic        o_br_hazir,
   input  logic [31:0] i_br_buyruk,
   input  logic [31:0] i_br_buyruk_adresi,
   input  logic [31:0] i_br_atlanan_adres,
   input  logic        i_br_atladi,
   input  logic        i_br_ongoru_yanlis,
   input  logic        i_ju_gecerli,
   output logic        o_ju_hazir,
   input  logic [31:0] i_ju_buyruk,
   input  logic [31:0] i_ju_buyruk_adresi,
   input  logic [31:0] i_ju_atlanan_adres,
   input  logic        i_ju_atladi,
   input  logic        i_ju_ongoru_yanlis,
   input  logic        i_temizle,
   input  logic        i_durdur,
   output logic        guncelle_gecerli_g,
   output logic [31:0] o_eski_buyruk,
   output logic [31:0] o_eski_buyruk_adresi,
   output logic        o_buyruk_atladi,
   output logic [31:0] o_atlanan_adres,
   output logic        o_ongoru_yanlis,
   output logic [15:0] o_yanlis_sayisi
);

   localparam int            AW    = $clog2(DERINLIK);
   localparam logic [AW:0]   DOLU  = (AW+1)'(DERINLIK);

   typedef struct packed {
      logic [31:0] buyruk;
      logic [31:0] adres;
      logic [31:0] atlanan;
      logic        atladi;
      logic        yanlis;
   } guncelleme_t;

   guncelleme_t   mem_q [DERINLIK];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   sayac_q, sayac_d;
   logic          rr_q, rr_d;
   logic          gecerli_q, gecerli_d;
   guncelleme_t   cikis_q, cikis_d;
   logic [15:0]   yanlis_sayisi_q, yanlis_sayisi_d;

   guncelleme_t   br_yuk, ju_yuk, giris;
   logic          br_izin, ju_izin;
   logic          dolu, bos, push, pop, bypass, yaz;

   assign br_yuk = '{buyruk: i_br_buyruk, adres: i_br_buyruk_adresi, atlanan: i_br_atlanan_adres,
                     atladi: i_br_atladi, yanlis: i_br_ongoru_yanlis};
   assign ju_yuk = '{buyruk: i_ju_buyruk, adres: i_ju_buyruk_adresi, atlanan: i_ju_atlanan_adres,
                     atladi: i_ju_atladi, yanlis: i_ju_ongoru_yanlis};

   // rr_q = 0 favours the branch unit when both request in the same cycle
   always_comb begin
      br_izin = i_br_gecerli;
      ju_izin = i_ju_gecerli;
      if (i_br_gecerli && i_ju_gecerli) begin
         br_izin = ~rr_q;
         ju_izin = rr_q;
      end
   end

   assign dolu = (sayac_q == DOLU);
   assign bos  = (sayac_q == '0);

   // rst_g gates hazir so neither requester sees a handshake while reset is held
   assign o_br_hazir = rst_g & ~dolu & ~i_temizle & br_izin;
   assign o_ju_hazir = rst_g & ~dolu & ~i_temizle & ju_izin;

   assign push  = (i_br_gecerli & o_br_hazir) | (i_ju_gecerli & o_ju_hazir);
   assign giris = o_ju_hazir ? ju_yuk : br_yuk;
   assign pop   = ~i_temizle & ~i_durdur & ~bos;

`ifdef GUNCELLEME_BYPASS_EN
   assign bypass = push & bos & ~i_durdur;
`else
   assign bypass = 1'b0;
`endif

   assign yaz = push & ~bypass;

   always_comb begin
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      sayac_d         = sayac_q;
      rr_d            = rr_q;
      gecerli_d       = 1'b0;
      cikis_d         = cikis_q;
      yanlis_sayisi_d = yanlis_sayisi_q;
      if (i_temizle) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         sayac_d  = '0;
      end else begin
         if (push && i_br_gecerli && i_ju_gecerli)
            rr_d = ~rr_q;
         if (pop) begin
            gecerli_d = 1'b1;
            cikis_d   = mem_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + 1'b1;
         end else if (bypass) begin
            gecerli_d = 1'b1;
            cikis_d   = giris;
         end
         if (yaz)
            wr_ptr_d = wr_ptr_q + 1'b1;
         case ({yaz, pop})
            2'b10:   sayac_d = sayac_q + 1'b1;
            2'b01:   sayac_d = sayac_q - 1'b1;
            default: sayac_d = sayac_q;
         endcase
      end
      if (gecerli_d && cikis_d.yanlis && (yanlis_sayisi_q != 16'hFFFF))
         yanlis_sayisi_d = yanlis_sayisi_q + 16'd1;
   end

   // NOTE: the storage array has no reset; occupancy and pointers alone decide what is valid.
   always_ff @(posedge clk_g) begin
      if (yaz)
         mem_q[wr_ptr_q] <= giris;
   end

   // NOTE: every register uses non-blocking assignment so all _q values update together at the edge.
   always_ff @(posedge clk_g or negedge rst_g) begin
      if (!rst_g) begin
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         sayac_q         <= '0;
         rr_q            <= 1'b0;
         gecerli_q       <= 1'b0;
         cikis_q         <= '0;
         yanlis_sayisi_q <= '0;
      end else begin
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         sayac_q         <= sayac_d;
         rr_q            <= rr_d;
         gecerli_q       <= gecerli_d;
         cikis_q         <= cikis_d;
         yanlis_sayisi_q <= yanlis_sayisi_d;
      end
   end

   assign guncelle_gecerli_g   = gecerli_q;
   assign o_eski_buyruk        = cikis_q.buyruk;
   assign o_eski_buyruk_adresi = cikis_q.adres;
   assign o_buyruk_atladi      = cikis_q.atladi;
   assign o_atlanan_adres      = cikis_q.atlanan;
   assign o_ongoru_yanlis      = cikis_q.yanlis;
   assign o_yanlis_sayisi      = yanlis_sayisi_q;

endmodule

// File: tb/tb_guncelleme_zamanlayici.sv
// Scoreboard bench for guncelleme_zamanlayici: a queue-level reference model predicts handshakes and update pulses.
module tb_guncelleme_zamanlayici;

   localparam int DERINLIK = 4;

   typedef struct {
      logic [31:0] buyruk;
      logic [31:0] adres;
      logic [31:0] hedef;
      logic        atladi;
      logic        yanlis;
   } req_t;

   typedef struct {
      req_t        r;
      logic [15:0] sayi;
      int          cyc;
   } beklenen_t;

   logic        clk_g = 1'b0;
   logic        rst_g;
   logic        i_br_gecerli, i_ju_gecerli, o_br_hazir, o_ju_hazir;
   logic [31:0] i_br_buyruk, i_br_buyruk_adresi, i_br_atlanan_adres;
   logic [31:0] i_ju_buyruk, i_ju_buyruk_adresi, i_ju_atlanan_adres;
   logic        i_br_atladi, i_br_ongoru_yanlis, i_ju_atladi, i_ju_ongoru_yanlis;
   logic        i_temizle, i_durdur;
   logic        guncelle_gecerli_g, o_buyruk_atladi, o_ongoru_yanlis;
   logic [31:0] o_eski_buyruk, o_eski_buyruk_adresi, o_atlanan_adres;
   logic [15:0] o_yanlis_sayisi;

   guncelleme_zamanlayici #(.DERINLIK(DERINLIK)) dut (
      .clk_g(clk_g), .rst_g(rst_g),
      .i_br_gecerli(i_br_gecerli), .o_br_hazir(o_br_hazir),
      .i_br_buyruk(i_br_buyruk), .i_br_buyruk_adresi(i_br_buyruk_adresi),
      .i_br_atlanan_adres(i_br_atlanan_adres), .i_br_atladi(i_br_atladi),
      .i_br_ongoru_yanlis(i_br_ongoru_yanlis),
      .i_ju_gecerli(i_ju_gecerli), .o_ju_hazir(o_ju_hazir),
      .i_ju_buyruk(i_ju_buyruk), .i_ju_buyruk_adresi(i_ju_buyruk_adresi),
      .i_ju_atlanan_adres(i_ju_atlanan_adres), .i_ju_atladi(i_ju_atladi),
      .i_ju_ongoru_yanlis(i_ju_ongoru_yanlis),
      .i_temizle(i_temizle), .i_durdur(i_durdur),
      .guncelle_gecerli_g(guncelle_gecerli_g), .o_eski_buyruk(o_eski_buyruk),
      .o_eski_buyruk_adresi(o_eski_buyruk_adresi), .o_buyruk_atladi(o_buyruk_atladi),
      .o_atlanan_adres(o_atlanan_adres), .o_ongoru_yanlis(o_ongoru_yanlis),
      .o_yanlis_sayisi(o_yanlis_sayisi)
   );

   always #5 clk_g = ~clk_g;

   int cyc = 0;
   always @(posedge clk_g) cyc <= cyc + 1;

   int nchk = 0;
   int nerr = 0;

   // reference model state: pending queue, round-robin owner, mispredict tally, expected pulses
   req_t        mq[$];
   beklenen_t   sb[$];
   bit          m_rr = 1'b0;
   logic [15:0] m_sayi = '0;
   req_t        bos_req = '{buyruk: '0, adres: '0, hedef: '0, atladi: 1'b0, yanlis: 1'b0};

   task automatic check(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
      nchk++;
      if (gercek !== beklenen) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", ad, gercek, beklenen, cyc);
      end
   endtask

   task automatic hata(input string ad);
      nchk++;
      nerr++;
      $display("FAIL %s (cycle %0d)", ad, cyc);
   endtask

   function automatic req_t yap(input logic [31:0] adres, input logic atladi, input logic yanlis);
      req_t r;
      r.buyruk = adres ^ 32'hA5A5_0000;
      r.adres  = adres;
      r.hedef  = adres + 32'h40;
      r.atladi = atladi;
      r.yanlis = yanlis;
      return r;
   endfunction

   function automatic req_t rastgele();
      req_t r;
      r.buyruk = $urandom;
      r.adres  = $urandom;
      r.hedef  = $urandom;
      r.atladi = 1'($urandom_range(0, 1));
      r.yanlis = 1'($urandom_range(0, 1));
      return r;
   endfunction

   // an update issued at the coming edge is visible for the whole cycle after it
   task automatic yayinla(input req_t r);
      if (r.yanlis && m_sayi != 16'hFFFF)
         m_sayi = m_sayi + 16'd1;
      sb.push_back('{r: r, sayi: m_sayi, cyc: cyc + 1});
   endtask

   task automatic adim(input logic bv, input req_t bp, input logic jv, input req_t jp,
                       input logic tem, input logic dur);
      bit br_sec, ju_sec, exp_br, exp_ju, gecti;
      req_t alinan;
      @(negedge clk_g);
      i_br_gecerli = bv;  i_br_buyruk = bp.buyruk; i_br_buyruk_adresi = bp.adres;
      i_br_atlanan_adres = bp.hedef; i_br_atladi = bp.atladi; i_br_ongoru_yanlis = bp.yanlis;
      i_ju_gecerli = jv;  i_ju_buyruk = jp.buyruk; i_ju_buyruk_adresi = jp.adres;
      i_ju_atlanan_adres = jp.hedef; i_ju_atladi = jp.atladi; i_ju_ongoru_yanlis = jp.yanlis;
      i_temizle = tem;
      i_durdur  = dur;
      #1;
      br_sec = (bv && jv) ? !m_rr : bv;
      ju_sec = (bv && jv) ?  m_rr : jv;
      exp_br = !tem && (mq.size() < DERINLIK) && br_sec;
      exp_ju = !tem && (mq.size() < DERINLIK) && ju_sec;
      check("br_hazir", 32'(o_br_hazir), 32'(exp_br));
      check("ju_hazir", 32'(o_ju_hazir), 32'(exp_ju));
      if (tem) begin
         mq.delete();
      end else begin
         gecti  = exp_br || exp_ju;
         alinan = exp_br ? bp : jp;
         if (gecti && bv && jv)
            m_rr = !m_rr;
`ifdef GUNCELLEME_BYPASS_EN
         if (gecti && mq.size() == 0 && !dur) begin
            yayinla(alinan);
            gecti = 1'b0;
         end
`endif
         if (!dur && mq.size() > 0)
            yayinla(mq.pop_front());
         if (gecti)
            mq.push_back(alinan);
      end
   endtask

   task automatic bosta(input int n);
      for (int i = 0; i < n; i++)
         adim(1'b0, bos_req, 1'b0, bos_req, 1'b0, 1'b0);
   endtask

   task automatic reset_uygula();
      @(negedge clk_g);
      #1;
      rst_g = 1'b0;
      i_br_gecerli = 1'b1;
      i_ju_gecerli = 1'b1;
      i_temizle = 1'b0;
      i_durdur  = 1'b0;
      #1;
      check("rst_gecerli", 32'(guncelle_gecerli_g), 0);
      check("rst_buyruk", o_eski_buyruk, 0);
      check("rst_adres", o_eski_buyruk_adresi, 0);
      check("rst_hedef", o_atlanan_adres, 0);
      check("rst_bayraklar", {30'd0, o_buyruk_atladi, o_ongoru_yanlis}, 0);
      check("rst_sayi", 32'(o_yanlis_sayisi), 0);
      check("rst_br_hazir", 32'(o_br_hazir), 0);
      check("rst_ju_hazir", 32'(o_ju_hazir), 0);
      mq.delete();
      sb.delete();
      m_rr   = 1'b0;
      m_sayi = '0;
      repeat (2) @(negedge clk_g);
      #1;
      i_br_gecerli = 1'b0;
      i_ju_gecerli = 1'b0;
      rst_g = 1'b1;
   endtask

   // monitor: every update pulse must match the oldest expected entry in value and cycle
   always @(negedge clk_g) begin
      if (rst_g) begin
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            hata("eksik_guncelleme");
            void'(sb.pop_front());
         end
         if (guncelle_gecerli_g) begin
            if (sb.size() == 0 || sb[0].cyc != cyc) begin
               hata("beklenmeyen_guncelleme");
            end else begin
               check("buyruk", o_eski_buyruk, sb[0].r.buyruk);
               check("buyruk_adresi", o_eski_buyruk_adresi, sb[0].r.adres);
               check("atlanan_adres", o_atlanan_adres, sb[0].r.hedef);
               check("atladi", 32'(o_buyruk_atladi), 32'(sb[0].r.atladi));
               check("ongoru_yanlis", 32'(o_ongoru_yanlis), 32'(sb[0].r.yanlis));
               check("yanlis_sayisi", 32'(o_yanlis_sayisi), 32'(sb[0].sayi));
               void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_g = 1'b0;
      i_br_gecerli = 1'b0; i_ju_gecerli = 1'b0; i_temizle = 1'b0; i_durdur = 1'b0;
      i_br_buyruk = '0; i_br_buyruk_adresi = '0; i_br_atlanan_adres = '0;
      i_br_atladi = 1'b0; i_br_ongoru_yanlis = 1'b0;
      i_ju_buyruk = '0; i_ju_buyruk_adresi = '0; i_ju_atlanan_adres = '0;
      i_ju_atladi = 1'b0; i_ju_ongoru_yanlis = 1'b0;
      reset_uygula();

      // single branch update, latency checked by the scoreboard cycle stamp
      adim(1'b1, yap(32'h100, 1'b1, 1'b0), 1'b0, bos_req, 1'b0, 1'b0);
      bosta(4);

      // contention from reset: BR, JU, BR, JU
      reset_uygula();
      for (int i = 0; i < 4; i++)
         adim(1'b1, yap(32'h200 + 32'(i), 1'b0, 1'b0), 1'b1, yap(32'h300 + 32'(i), 1'b1, 1'b0), 1'b0, 1'b0);
      bosta(6);

      // stalled fill: 4 accepted, 5th refused, then drain with BR still requesting
      for (int i = 0; i < 5; i++)
         adim(1'b1, yap(32'h400 + 32'(i), 1'b0, 1'b0), 1'b0, bos_req, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++)
         adim(1'b1, yap(32'h410 + 32'(i), 1'b1, 1'b0), 1'b0, bos_req, 1'b0, 1'b0);
      bosta(8);

      // flush with three entries queued and a BR request pending; flush outranks stall
      for (int i = 0; i < 3; i++)
         adim(1'b1, yap(32'h500 + 32'(i), 1'b0, 1'b0), 1'b0, bos_req, 1'b0, 1'b1);
      adim(1'b1, yap(32'h5F0, 1'b0, 1'b0), 1'b0, bos_req, 1'b1, 1'b1);
      bosta(4);

      // mispredict tally 1,0,1 -> 2
      reset_uygula();
      adim(1'b1, yap(32'h600, 1'b0, 1'b1), 1'b0, bos_req, 1'b0, 1'b0);
      adim(1'b1, yap(32'h604, 1'b0, 1'b0), 1'b0, bos_req, 1'b0, 1'b0);
      adim(1'b1, yap(32'h608, 1'b1, 1'b1), 1'b0, bos_req, 1'b0, 1'b0);
      bosta(4);
      check("yanlis_iki", 32'(o_yanlis_sayisi), 32'd2);

      // saturation: preset the tally, one more mispredict must leave it at FFFF
      force dut.yanlis_sayisi_q = 16'hFFFF;
      m_sayi = 16'hFFFF;
      bosta(1);
      release dut.yanlis_sayisi_q;
      adim(1'b1, yap(32'h700, 1'b1, 1'b1), 1'b0, bos_req, 1'b0, 1'b0);
      bosta(4);
      check("yanlis_doygun", 32'(o_yanlis_sayisi), 32'h0000_FFFF);

      // reset mid-stream with two entries queued, then nothing may appear
      reset_uygula();
      for (int i = 0; i < 2; i++)
         adim(1'b1, yap(32'h800 + 32'(i), 1'b0, 1'b0), 1'b0, bos_req, 1'b0, 1'b1);
      reset_uygula();
      bosta(5);
      adim(1'b0, bos_req, 1'b1, yap(32'h900, 1'b1, 1'b1), 1'b0, 1'b0);
      bosta(4);

      // randomized traffic with stalls and occasional flushes
      for (int i = 0; i < 600; i++)
         adim(1'($urandom_range(0, 1)), rastgele(), 1'($urandom_range(0, 1)), rastgele(),
              ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) == 0));

      for (int i = 0; i < 16 && (sb.size() + mq.size()) > 0; i++)
         bosta(1);
      check("kuyruk_bos", 32'(sb.size() + mq.size()), 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
